// File: rtl/stall_pipe_pkg.sv
// Shared constants and pipeline record layouts for the stall_pipe_sched block.
//   W_DEF    : default operand/result width
//   IDW_MAX  : id width covering the largest supported requester count (8)
//   s1_rec_t : stage-1 record {r1, r2, r3, r4, id, v} at default width
//   s2_rec_t : stage-2 record {d1, d2, id, v} at default width
// The top module re-declares these records locally so that the field widths
// follow its W/IDW parameters; the layouts here are the reference shape.
package stall_pipe_pkg;

    localparam int W_DEF   = 16;
    localparam int IDW_MAX = 3;

    typedef struct packed {
        logic [W_DEF-1:0]   r1;
        logic [W_DEF-1:0]   r2;
        logic [W_DEF-1:0]   r3;
        logic [W_DEF-1:0]   r4;
        logic [IDW_MAX-1:0] id;
        logic               v;
    } s1_rec_t;

    typedef struct packed {
        logic [W_DEF-1:0]   d1;
        logic [W_DEF-1:0]   d2;
        logic [IDW_MAX-1:0] id;
        logic               v;
    } s2_rec_t;

endpackage

// File: rtl/stall_pipe_sched_rr_arb.sv
// Combinational round-robin arbiter.
//   req   : request vector, one bit per requester
//   ptr   : index of the requester holding top priority this cycle
//   grant : one-hot (or zero) winner, first set req bit at or above ptr
//           scanning upward with wrap-around
// The pointer register lives in the parent so that it can be frozen by stall.
module rr_arb #(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant
);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stall_pipe_sched.sv
// Round-robin scheduler feeding a shared two-stage sum pipeline.
//   clk, rst_n        : clock and synchronous active-low reset
//   req_valid/ready   : per-requester handshake
//   req_a/b/c         : packed operands, requester i at [i*W +: W]
//   out_valid/ready   : result handshake toward the single consumer
//   out_id            : requester id of the result
//   out_sum, out_chk  : (a+b)+c and (a+c)+b, both modulo 2^W
//   stall             : whole pipeline (both stages and rr pointer) frozen
//   busy              : either stage holds a valid item
module stall_pipe_sched
    import stall_pipe_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = W_DEF,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*W-1:0] req_c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDW-1:0]    out_id,
    output logic [W-1:0]      out_sum,
    output logic [W-1:0]      out_chk,
    output logic              stall,
    output logic              busy
);

    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    typedef struct packed {
        logic [W-1:0]   r1;
        logic [W-1:0]   r2;
        logic [W-1:0]   r3;
        logic [W-1:0]   r4;
        logic [IDW-1:0] id;
        logic           v;
    } s1_t;

    typedef struct packed {
        logic [W-1:0]   d1;
        logic [W-1:0]   d2;
        logic [IDW-1:0] id;
        logic           v;
    } s2_t;

    s1_t            s1_q, s1_d;
    s2_t            s2_q, s2_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  win_id;
    logic [W-1:0]    a_sel, b_sel, c_sel;
    logic            stall_w;
    logic            accept;

    rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    // grant is one-hot, so the OR-style mux picks exactly the winner.
    always_comb begin
        win_id = '0;
        a_sel  = '0;
        b_sel  = '0;
        c_sel  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_id = IDW'(i);
                a_sel  = req_a[i*W +: W];
                b_sel  = req_b[i*W +: W];
                c_sel  = req_c[i*W +: W];
            end
        end
    end

    // Simple global freeze: a full stage 2 that cannot drain holds everything,
    // even when stage 1 is empty.
    assign stall_w   = s2_q.v && !out_ready;
    assign accept    = !stall_w && (|grant);
    assign req_ready = grant & {NREQ{!stall_w && rst_n}};

    always_comb begin
        s1_d     = s1_q;
        s2_d     = s2_q;
        rr_ptr_d = rr_ptr_q;
        if (!stall_w) begin
            s2_d.d1 = s1_q.r1 + s1_q.r2;
            s2_d.d2 = s1_q.r3 + s1_q.r4;
            s2_d.id = s1_q.id;
            s2_d.v  = s1_q.v;
            if (accept) begin
                s1_d.r1  = a_sel + b_sel;
                s1_d.r2  = c_sel;
                s1_d.r3  = a_sel + c_sel;
                s1_d.r4  = b_sel;
                s1_d.id  = win_id;
                s1_d.v   = 1'b1;
                rr_ptr_d = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
            end else begin
                // Bubble: operand registers keep their old contents.
                s1_d.v = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign out_valid = s2_q.v;
    assign out_sum   = s2_q.d1;
    assign out_chk   = s2_q.d2;
    assign out_id    = s2_q.id;
    assign stall     = stall_w;
    assign busy      = s1_q.v || s2_q.v;

    // The two datapaths must agree in every stage that carries valid data.
    logic [W-1:0] s1_lhs, s1_rhs;
    assign s1_lhs = s1_q.r1 + s1_q.r2;
    assign s1_rhs = s1_q.r3 + s1_q.r4;

    a_out_match: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> (out_sum == out_chk));

    a_s1_match: assert property (@(posedge clk) disable iff (!rst_n)
        s1_q.v |-> (s1_lhs == s1_rhs));

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant));

    a_stall_no_ready: assert property (@(posedge clk) disable iff (!rst_n)
        stall_w |-> (req_ready == '0));

    a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=>
            (out_valid && $stable(out_sum) && $stable(out_id)));

endmodule

// File: tb/tb_stall_pipe_sched.sv
module tb_stall_pipe_sched;

    localparam int NREQ = 2;
    localparam int W    = 16;
    localparam int IDW  = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a, req_b, req_c;
    logic              out_valid;
    logic              out_ready;
    logic [IDW-1:0]    out_id;
    logic [W-1:0]      out_sum, out_chk;
    logic              stall, busy;

    logic [W-1:0] op_a [NREQ];
    logic [W-1:0] op_b [NREQ];
    logic [W-1:0] op_c [NREQ];

    assign req_a = {op_a[1], op_a[0]};
    assign req_b = {op_b[1], op_b[0]};
    assign req_c = {op_c[1], op_c[0]};

    always #5 clk = ~clk;

    stall_pipe_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_sum   (out_sum),
        .out_chk   (out_chk),
        .stall     (stall),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: two pipeline slots holding the final sum directly,
    // plus the priority pointer.
    bit           m1v = 1'b0, m2v = 1'b0;
    logic [W-1:0] m1s = '0, m2s = '0;
    int           m1id = 0, m2id = 0, mptr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mgrant();
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_checks();
        int         g;
        logic [1:0] er;
        bit         mst;
        g   = mgrant();
        mst = m2v && !out_ready;
        er  = '0;
        if (rst_n && !mst && g >= 0) er = 2'(1 << g);
        chk("m_ready", 32'(req_ready), 32'(er));
        chk("m_stall", 32'(stall), 32'(mst));
        chk("m_valid", 32'(out_valid), 32'(m2v));
        chk("m_busy",  32'(busy), 32'(m1v || m2v));
        if (m2v) begin
            chk("m_sum", 32'(out_sum), 32'(m2s));
            chk("m_chk", 32'(out_chk), 32'(m2s));
            chk("m_id",  32'(out_id), 32'(m2id));
        end
    endtask

    task automatic model_step();
        int g;
        g = mgrant();
        if (!rst_n) begin
            m1v  = 1'b0;
            m2v  = 1'b0;
            mptr = 0;
        end else if (!(m2v && !out_ready)) begin
            m2v  = m1v;
            m2s  = m1s;
            m2id = m1id;
            if (g >= 0) begin
                m1v  = 1'b1;
                m1s  = op_a[g] + op_b[g] + op_c[g];
                m1id = g;
                mptr = (g + 1) % NREQ;
            end else begin
                m1v = 1'b0;
            end
        end
    endtask

    task automatic run_cycle();
        #1;
        model_checks();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    typedef struct {
        bit           rst;
        logic [1:0]   vld;
        logic [W-1:0] a0, b0, c0, a1, b1, c1;
        bit           ordy;
        logic [1:0]   e_rdy;
        bit           e_stall, e_ov, e_busy;
        logic [W-1:0] e_sum;
        int           e_id;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(bit rst, logic [1:0] vld,
                                logic [W-1:0] a0, logic [W-1:0] b0, logic [W-1:0] c0,
                                logic [W-1:0] a1, logic [W-1:0] b1, logic [W-1:0] c1,
                                bit ordy, logic [1:0] e_rdy, bit e_stall, bit e_ov,
                                bit e_busy, logic [W-1:0] e_sum, int e_id);
        vec_t v;
        v.rst = rst; v.vld = vld;
        v.a0 = a0; v.b0 = b0; v.c0 = c0; v.a1 = a1; v.b1 = b1; v.c1 = c1;
        v.ordy = ordy; v.e_rdy = e_rdy; v.e_stall = e_stall; v.e_ov = e_ov;
        v.e_busy = e_busy; v.e_sum = e_sum; v.e_id = e_id;
        return v;
    endfunction

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0; op_b[i] = '0; op_c[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);

        //          rst vld  a0       b0  c0  a1 b1 c1 ordy rdy  st ov bz sum      id
        tab.push_back(mk(0, 2'b11, 16'h0,    0,  0,  0, 0, 0, 1, 2'b00, 0, 0, 0, 16'h0,  0));
        tab.push_back(mk(1, 2'b01, 16'h1,    2,  3,  0, 0, 0, 1, 2'b01, 0, 0, 0, 16'h0,  0));
        tab.push_back(mk(1, 2'b00, 16'h0,    0,  0,  0, 0, 0, 1, 2'b00, 0, 0, 1, 16'h0,  0));
        tab.push_back(mk(1, 2'b01, 16'hFFFF, 1,  2,  0, 0, 0, 1, 2'b01, 0, 1, 1, 16'h6,  0));
        tab.push_back(mk(1, 2'b00, 16'h0,    0,  0,  0, 0, 0, 1, 2'b00, 0, 0, 1, 16'h0,  0));
        tab.push_back(mk(1, 2'b10, 16'h0,    0,  0,  5, 6, 7, 1, 2'b10, 0, 1, 1, 16'h2,  0));
        tab.push_back(mk(1, 2'b11, 16'd10,  20, 30,  1, 1, 1, 1, 2'b01, 0, 0, 1, 16'h0,  0));
        tab.push_back(mk(1, 2'b11, 16'd10,  20, 30,  1, 1, 1, 0, 2'b00, 1, 1, 1, 16'd18, 1));
        tab.push_back(mk(1, 2'b11, 16'd10,  20, 30,  1, 1, 1, 0, 2'b00, 1, 1, 1, 16'd18, 1));
        tab.push_back(mk(1, 2'b11, 16'd10,  20, 30,  1, 1, 1, 0, 2'b00, 1, 1, 1, 16'd18, 1));
        tab.push_back(mk(1, 2'b11, 16'd10,  20, 30,  1, 1, 1, 1, 2'b10, 0, 1, 1, 16'd18, 1));
        tab.push_back(mk(1, 2'b00, 16'h0,    0,  0,  0, 0, 0, 1, 2'b00, 0, 1, 1, 16'd60, 0));
        tab.push_back(mk(1, 2'b00, 16'h0,    0,  0,  0, 0, 0, 1, 2'b00, 0, 1, 1, 16'd3,  1));
        tab.push_back(mk(1, 2'b00, 16'h0,    0,  0,  0, 0, 0, 1, 2'b00, 0, 0, 0, 16'h0,  0));

        foreach (tab[r]) begin
            rst_n     = tab[r].rst;
            req_valid = tab[r].vld;
            op_a[0] = tab[r].a0; op_b[0] = tab[r].b0; op_c[0] = tab[r].c0;
            op_a[1] = tab[r].a1; op_b[1] = tab[r].b1; op_c[1] = tab[r].c1;
            out_ready = tab[r].ordy;
            #1;
            chk($sformatf("t%0d_ready", r), 32'(req_ready), 32'(tab[r].e_rdy));
            chk($sformatf("t%0d_stall", r), 32'(stall), 32'(tab[r].e_stall));
            chk($sformatf("t%0d_valid", r), 32'(out_valid), 32'(tab[r].e_ov));
            chk($sformatf("t%0d_busy", r), 32'(busy), 32'(tab[r].e_busy));
            if (tab[r].e_ov) begin
                chk($sformatf("t%0d_sum", r), 32'(out_sum), 32'(tab[r].e_sum));
                chk($sformatf("t%0d_chk", r), 32'(out_chk), 32'(tab[r].e_sum));
                chk($sformatf("t%0d_id", r), 32'(out_id), 32'(tab[r].e_id));
            end
            run_cycle();
        end

        // Contention: both requesters always valid; grants must alternate.
        rst_n     = 1'b1;
        req_valid = 2'b11;
        out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            op_a[0] = 16'(n);       op_b[0] = 16'(2 * n); op_c[0] = 16'h100;
            op_a[1] = 16'(n + 50);  op_b[1] = 16'h7;      op_c[1] = 16'h200;
            run_cycle();
        end

        // Reset with both stages full, then the first grant must go to 0.
        rst_n = 1'b0;
        run_cycle();
        rst_n = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_busy",  32'(busy), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'(2'b01));
        run_cycle();

        // Randomised traffic with backpressure and occasional resets.
        for (int n = 0; n < 800; n++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            req_valid = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NREQ; i++) begin
                op_a[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                op_b[i] = 16'($urandom);
                op_c[i] = 16'($urandom);
            end
            run_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
